// File: rtl/spi_slave.sv
// SPI mode-0 slave with synchronized pins and a one-deep transmit buffer.
// Define SPI_SLAVE_LSB_FIRST_EN to shift LSB first in both directions (default MSB first).
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic                    sclk_hist_q, ss_hist_q;
    logic [DATA_WIDTH-1:0]   tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0]   buf_q, buf_d, rx_data_q, rx_data_d;
    logic                    buf_full_q, buf_full_d, rx_valid_q, rx_valid_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall, active, load;
    logic tx_bit;
    logic [DATA_WIDTH-1:0] tx_shifted, rx_shifted;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign ss_rise   = ss_s & ~ss_hist_q;
    assign ss_fall   = ~ss_s & ss_hist_q;
    assign active    = (state_q == ACTIVE);
    // A deselect in the same cycle as a word-boundary sclk fall wins; nothing is loaded.
    assign load      = ss_fall | (active & sclk_fall & (cnt_q == '0) & ~ss_rise);

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign tx_bit     = tx_sr_q[0];
    assign tx_shifted = {1'b0, tx_sr_q[DATA_WIDTH-1:1]};
    assign rx_shifted = {mosi_s, rx_sr_q[DATA_WIDTH-1:1]};
`else
    assign tx_bit     = tx_sr_q[DATA_WIDTH-1];
    assign tx_shifted = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
    assign rx_shifted = {rx_sr_q[DATA_WIDTH-2:0], mosi_s};
`endif

    assign miso     = active & tx_bit;
    assign tx_ready = ~buf_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = active;

    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        cnt_d      = cnt_q;

        // An empty buffer hit by a load event hands tx_data straight to the shifter.
        if (tx_valid && !buf_full_q && !load) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ss_fall) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rx_sr_d = '0;
                    tx_sr_d = '0;
                end else if (sclk_rise) begin
                    rx_sr_d = rx_shifted;
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        cnt_d      = '0;
                        rx_data_d  = rx_shifted;
                        rx_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sclk_fall && cnt_q != '0) begin
                    tx_sr_d = tx_shifted;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            if (buf_full_q) begin
                tx_sr_d    = buf_q;
                buf_full_d = 1'b0;
            end else if (tx_valid) begin
                tx_sr_d = tx_data;
            end else begin
                tx_sr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            ss_hist_q   <= 1'b1;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_hist_q <= sclk_s;
            ss_hist_q   <= ss_s;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural mode-0 master plus a fabric-side TX feeder.
module tb_spi_slave;
    localparam int PH = 10;

    logic       clk = 1'b0;
    logic       rst, sclk, ss, mosi, miso;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, busy;
    int         n_chk = 0, n_bad = 0, vcnt = 0;

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Counts high cycles of rx_valid, so a stretched pulse shows up as an extra count.
    always @(negedge clk) if (rx_valid) vcnt <= vcnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", 32'(tx_ready), 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic frame_begin;
        ss = 1'b0;
        repeat (PH) @(negedge clk);
    endtask

    task automatic frame_end;
        repeat (PH) @(negedge clk);
        ss = 1'b1;
        repeat (PH) @(negedge clk);
    endtask

    task automatic spi_word(input logic [7:0] txw, output logic [7:0] rxw);
        rxw = '0;
        for (int i = 0; i < 8; i++) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
            mosi = txw[i];
`else
            mosi = txw[7-i];
`endif
            repeat (PH) @(negedge clk);
`ifdef SPI_SLAVE_LSB_FIRST_EN
            rxw = {miso, rxw[7:1]};
`else
            rxw = {rxw[6:0], miso};
`endif
            sclk = 1'b1;
            repeat (PH) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r, r0, r1, r2;
        int base;
        rst = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_miso", 32'(miso), 0);
        chk("rst_tx_ready", 32'(tx_ready), 1);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

`ifdef SPI_SLAVE_LSB_FIRST_EN
        push(8'h01);
        frame_begin;
        chk("lsb_first_miso", 32'(miso), 1);
        base = vcnt;
        spi_word(8'h80, r);
        frame_end;
        chk("lsb_rx_data", 32'(rx_data), 'h80);
        chk("lsb_master_rx", 32'(r), 'h01);
        chk("lsb_pulses", 32'(vcnt - base), 1);
`else
        // basic frame with a preloaded buffer
        push(8'h3C);
        chk("t1_buf_full", 32'(tx_ready), 0);
        frame_begin;
        chk("t1_busy", 32'(busy), 1);
        chk("t1_buf_loaded", 32'(tx_ready), 1);
        base = vcnt;
        spi_word(8'hA5, r);
        frame_end;
        chk("t1_master_rx", 32'(r), 'h3C);
        chk("t1_rx_data", 32'(rx_data), 'hA5);
        chk("t1_pulses", 32'(vcnt - base), 1);
        chk("t1_busy_end", 32'(busy), 0);

        // underrun: nothing offered
        frame_begin;
        base = vcnt;
        spi_word(8'hFF, r);
        frame_end;
        chk("t2_master_rx", 32'(r), 'h00);
        chk("t2_rx_data", 32'(rx_data), 'hFF);
        chk("t2_pulses", 32'(vcnt - base), 1);

        // three back-to-back words with live refills
        push(8'h10);
        frame_begin;
        base = vcnt;
        fork
            begin
                spi_word(8'h01, r0);
                chk("t3_rx0", 32'(rx_data), 'h01);
                spi_word(8'h02, r1);
                chk("t3_rx1", 32'(rx_data), 'h02);
                spi_word(8'h03, r2);
                chk("t3_rx2", 32'(rx_data), 'h03);
            end
            begin
                push(8'h20);
                push(8'h30);
            end
        join
        frame_end;
        chk("t3_m0", 32'(r0), 'h10);
        chk("t3_m1", 32'(r1), 'h20);
        chk("t3_m2", 32'(r2), 'h30);
        chk("t3_pulses", 32'(vcnt - base), 3);

        // deselect after 5 sclk edges; buffered word must survive
        push(8'h77);
        frame_begin;
        push(8'h99);
        base = vcnt;
        mosi = 1'b1;
        for (int e = 0; e < 5; e++) begin
            sclk = ~sclk;
            repeat (PH) @(negedge clk);
        end
        ss = 1'b1;
        repeat (PH) @(negedge clk);
        sclk = 1'b0;
        repeat (PH) @(negedge clk);
        chk("t4_no_pulse", 32'(vcnt - base), 0);
        chk("t4_rx_held", 32'(rx_data), 'h03);
        chk("t4_buf_kept", 32'(tx_ready), 0);
        chk("t4_busy", 32'(busy), 0);
        frame_begin;
        spi_word(8'h5A, r);
        frame_end;
        chk("t4_rx_data", 32'(rx_data), 'h5A);
        chk("t4_master_rx", 32'(r), 'h99);
        chk("t4_pulses", 32'(vcnt - base), 1);

        // asynchronous reset in the middle of a word
        push(8'hFF);
        frame_begin;
        push(8'h81);
        chk("t5_buf_full", 32'(tx_ready), 0);
        chk("t5_miso_pre", 32'(miso), 1);
        sclk = 1'b1;
        repeat (PH) @(negedge clk);
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_miso", 32'(miso), 0);
        chk("t5_tx_ready", 32'(tx_ready), 1);
        chk("t5_rx_data", 32'(rx_data), 0);
        chk("t5_rx_valid", 32'(rx_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        ss = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (PH) @(negedge clk);
        push(8'hE7);
        frame_begin;
        base = vcnt;
        spi_word(8'hC3, r);
        frame_end;
        chk("t5_rx_after", 32'(rx_data), 'hC3);
        chk("t5_master_rx", 32'(r), 'hE7);
        chk("t5_pulses", 32'(vcnt - base), 1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
